// File: rtl/router_fsm_1x3.sv
// Control FSM for a 1-in/3-out packet router: address decode and load sequencing into the target FIFO.
// Latency: Moore outputs decoded from the state register, so they change one cycle after the causing input.
// Backpressure: fifo_full stalls loading, a non-empty target FIFO holds the header, and a soft reset aborts.
module router_fsm_1x3 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       low_pkt_valid,
  input  logic       parity_done,
  input  logic [1:0] data_in,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_en_reg,
  output logic       rst_int_reg,
  output logic       lfd_state,
  output logic       busy
);

  // Every 3-bit encoding is a named state; the default arm in the
  // next-state logic still steers any corrupted value back to decode.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_addr;

  logic       w_addr_ok;
  logic       w_empty_din;
  logic       w_empty_addr;
  logic       w_soft_rst;
  logic       w_addr_load;

  // Address 3 is not a real output port and must never start a packet.
  assign w_addr_ok   = (data_in != 2'd3);
  assign w_addr_load = (r_state == DECODE_ADDRESS) && pkt_valid && w_addr_ok;

  // Select the empty flag of the port named by the incoming header.
  always_comb begin
    w_empty_din = 1'b0;
    case (data_in)
      2'd0:    w_empty_din = fifo_empty_0;
      2'd1:    w_empty_din = fifo_empty_1;
      2'd2:    w_empty_din = fifo_empty_2;
      default: w_empty_din = 1'b0;
    endcase
  end

  // Select the empty flag of the port the current packet is bound to.
  always_comb begin
    w_empty_addr = 1'b0;
    case (r_addr)
      2'd0:    w_empty_addr = fifo_empty_0;
      2'd1:    w_empty_addr = fifo_empty_1;
      2'd2:    w_empty_addr = fifo_empty_2;
      default: w_empty_addr = 1'b0;
    endcase
  end

  // Only the timeout of the port this packet targets may abort it.
  always_comb begin
    w_soft_rst = 1'b0;
    case (r_addr)
      2'd0:    w_soft_rst = soft_reset_0;
      2'd1:    w_soft_rst = soft_reset_1;
      2'd2:    w_soft_rst = soft_reset_2;
      default: w_soft_rst = 1'b0;
    endcase
  end

  // Capture the destination port when a valid header is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr <= 2'b00;
    end else if (w_addr_load) begin
      r_addr <= data_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a matching soft reset overrides every transition.
  always_comb begin
    w_next_state = r_state;
    if (w_soft_rst) begin
      w_next_state = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (pkt_valid && w_addr_ok) begin
            w_next_state = w_empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: begin
          w_next_state = LOAD_DATA;
        end
        LOAD_DATA: begin
          // A full FIFO outranks the end of the packet.
          if (fifo_full) begin
            w_next_state = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            w_next_state = LOAD_PARITY;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            w_next_state = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          // Parity already captured means the packet is finished.
          if (parity_done) begin
            w_next_state = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            w_next_state = LOAD_PARITY;
          end else begin
            w_next_state = LOAD_DATA;
          end
        end
        LOAD_PARITY: begin
          w_next_state = CHECK_PARITY_ERROR;
        end
        CHECK_PARITY_ERROR: begin
          w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (w_empty_addr) begin
            w_next_state = LOAD_FIRST_DATA;
          end
        end
        default: begin
          w_next_state = DECODE_ADDRESS;
        end
      endcase
    end
  end

  // Moore outputs: pure decodes of the state register.
  assign detect_add   = (r_state == DECODE_ADDRESS);
  assign lfd_state    = (r_state == LOAD_FIRST_DATA);
  assign ld_state     = (r_state == LOAD_DATA);
  assign laf_state    = (r_state == LOAD_AFTER_FULL);
  assign full_state   = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg  = (r_state == CHECK_PARITY_ERROR);
  assign write_en_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                        (r_state == LOAD_AFTER_FULL);
  assign busy         = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm_1x3.sv
// Bench for router_fsm_1x3: per-cycle expected output vectors queued at drive time.
// Latency: outputs checked #1 after each rising edge, one cycle after the stimulus.
// Backpressure: fifo_full stalls, busy destination and soft resets exercised directly.
module tb_router_fsm_1x3;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       low_pkt_valid;
  logic       parity_done;
  logic [1:0] data_in;
  logic       detect_add;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_en_reg;
  logic       rst_int_reg;
  logic       lfd_state;
  logic       busy;

  // Output vector: {detect_add, lfd, ld, laf, full, rst_int, write_en, busy}
  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0010;
  localparam logic [7:0] E_LAF = 8'b0001_0011;
  localparam logic [7:0] E_FUL = 8'b0000_1001;
  localparam logic [7:0] E_CPE = 8'b0000_0101;
  localparam logic [7:0] E_LP  = 8'b0000_0011;
  localparam logic [7:0] E_WTE = 8'b0000_0001;

  logic [7:0] w_outs;
  assign w_outs = {detect_add, lfd_state, ld_state, laf_state,
                   full_state, rst_int_reg, write_en_reg, busy};

  int         n_tests;
  int         n_fail;
  logic [7:0] exp_q[$];

  router_fsm_1x3 dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .low_pkt_valid (low_pkt_valid),
    .parity_done   (parity_done),
    .data_in       (data_in),
    .detect_add    (detect_add),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_en_reg  (write_en_reg),
    .rst_int_reg   (rst_int_reg),
    .lfd_state     (lfd_state),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Queue the expectation with the stimulus, then compare once the edge has passed.
  task automatic step(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, w_outs, e);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    resetn        = 1'b0;
    pkt_valid     = 1'b0;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    low_pkt_valid = 1'b0;
    parity_done   = 1'b0;
    data_in       = 2'd0;

    #20;
    chk("reset", w_outs, E_DA);
    #2 resetn = 1'b1;
    step("idle", E_DA);

    // Normal packet to port 1
    pkt_valid = 1'b1; data_in = 2'd1;
    step("norm_lfd", E_LFD);
    step("norm_ld", E_LD);
    step("norm_ld2", E_LD);
    pkt_valid = 1'b0;
    step("norm_lp", E_LP);
    step("norm_cpe", E_CPE);
    step("norm_da", E_DA);

    // Busy destination, port 2
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    step("busy_wte", E_WTE);
    pkt_valid = 1'b0; data_in = 2'd1;
    step("busy_wte2", E_WTE);
    fifo_empty_2 = 1'b1; pkt_valid = 1'b1;
    step("busy_lfd", E_LFD);
    step("busy_ld", E_LD);

    // Full stall, low_pkt_valid path
    fifo_full = 1'b1;
    step("full_1", E_FUL);
    step("full_2", E_FUL);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step("laf_1", E_LAF);
    step("laf_to_lp", E_LP);
    fifo_full = 1'b1; low_pkt_valid = 1'b0;
    step("lp_to_cpe", E_CPE);
    step("cpe_to_full", E_FUL);
    fifo_full = 1'b0;
    step("laf_2", E_LAF);
    step("laf_to_ld", E_LD);
    fifo_full = 1'b1;
    step("full_3", E_FUL);
    fifo_full = 1'b0;
    step("laf_3", E_LAF);
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    step("laf_parity_done", E_DA);
    parity_done = 1'b0; low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step("idle2", E_DA);

    // Soft reset on port 0 packet
    pkt_valid = 1'b1; data_in = 2'd0;
    step("sr_lfd", E_LFD);
    step("sr_ld", E_LD);
    soft_reset_1 = 1'b1;
    step("sr_other_port", E_LD);
    soft_reset_1 = 1'b0; soft_reset_2 = 1'b1;
    step("sr_other_port2", E_LD);
    soft_reset_2 = 1'b0; soft_reset_0 = 1'b1; pkt_valid = 1'b0;
    step("sr_match", E_DA);
    soft_reset_0 = 1'b0;

    // Soft reset while waiting on a busy port 2
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    step("sr_wte", E_WTE);
    pkt_valid = 1'b0; soft_reset_2 = 1'b1;
    step("sr_wte_abort", E_DA);
    soft_reset_2 = 1'b0; fifo_empty_2 = 1'b1;

    // Invalid address
    pkt_valid = 1'b1; data_in = 2'd3;
    step("inv_1", E_DA);
    step("inv_2", E_DA);
    pkt_valid = 1'b0;

    // Asynchronous reset mid-packet
    pkt_valid = 1'b1; data_in = 2'd1;
    step("ar_lfd", E_LFD);
    step("ar_ld", E_LD);
    #2 resetn = 1'b0;
    #1 chk("async_reset", w_outs, E_DA);
    #50 chk("reset_hold", w_outs, E_DA);
    pkt_valid = 1'b0;
    resetn = 1'b1;
    step("post_reset", E_DA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
